hazard_control_unit: RTL

Pipeline hazard sequencer for the 5-stage LEGv8 core. It detects load-use hazards, branch redirects and data-memory wait states, and drives the PC/IF-ID write enables, the ID/EX bubble, the IF/ID flush and the EX/MEM hold. It sits beside the forwarding logic in the ID/EX boundary area and owns every stall and flush decision in the pipeline.

---
 rtl/hazard_control_unit_if.sv | 38 +++
 rtl/hazard_control_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit_if.sv
`default_nettype none
// ============================================================================
// hazard_control_unit_if : hazard detection inputs and stall/flush controls
// Revision: 1.0
// ============================================================================
interface hazard_control_unit_if;
  logic        idex_mem_read;
  logic [4:0]  idex_rd;
  logic [4:0]  ifid_rn;
  logic [4:0]  ifid_rm;
  logic        ifid_uses_rn;
  logic        ifid_uses_rm;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        exmem_hold;
  logic        mem_timeout;
  logic [15:0] stall_cycles;

  modport master (
    output idex_mem_read, idex_rd, ifid_rn, ifid_rm, ifid_uses_rn, ifid_uses_rm,
           branch_taken, dmem_req, dmem_ready,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, exmem_hold,
           mem_timeout, stall_cycles
  );

  modport slave (
    input  idex_mem_read, idex_rd, ifid_rn, ifid_rm, ifid_uses_rn, ifid_uses_rm,
           branch_taken, dmem_req, dmem_ready,
    output pc_write, ifid_write, idex_bubble, ifid_flush, exmem_hold,
           mem_timeout, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// hazard_control_unit : load-use / branch-flush / memory-wait sequencer
// Revision: 1.0
// ============================================================================
module hazard_control_unit #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int FLUSH_SLOTS     = 1,
  parameter int MEM_TIMEOUT     = 64
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  hazard_control_unit_if.slave hz
);
  localparam int               c_WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT);
  localparam logic [1:0]       c_LU_REM   = 2'(LOAD_USE_CYCLES - 1);
  localparam logic [1:0]       c_FL_REM   = 2'(FLUSH_SLOTS - 1);

  localparam logic [1:0] c_RUN        = 2'd0;
  localparam logic [1:0] c_LOAD_STALL = 2'd1;
  localparam logic [1:0] c_FLUSH      = 2'd2;

  logic [1:0]          r_state, w_state_nxt;
  logic [1:0]          r_rem, w_rem_nxt;
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_mem_timeout;
  logic [15:0]         r_stall_cycles;
  logic                w_hazard, w_freeze;
  logic                w_pc_write, w_ifid_write, w_idex_bubble, w_ifid_flush, w_exmem_hold;

  // XZR is never a real destination, so it cannot create a dependency
  assign w_hazard = hz.idex_mem_read && (hz.idex_rd != 5'd31) &&
                    ((hz.ifid_uses_rn && (hz.ifid_rn == hz.idex_rd)) ||
                     (hz.ifid_uses_rm && (hz.ifid_rm == hz.idex_rd)));
  // Once the wait budget is spent the freeze is dropped for one cycle
  assign w_freeze = hz.dmem_req && !hz.dmem_ready && (r_wait != c_WAIT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_RUN;
      r_rem   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    if (!w_freeze) begin
      case (r_state)
        c_RUN: begin
          if (w_hazard) begin
            if (LOAD_USE_CYCLES > 1) begin
              w_state_nxt = c_LOAD_STALL;
              w_rem_nxt   = c_LU_REM;
            end
          end else if (hz.branch_taken && (FLUSH_SLOTS > 1)) begin
            w_state_nxt = c_FLUSH;
            w_rem_nxt   = c_FL_REM;
          end
        end
        c_LOAD_STALL, c_FLUSH: begin
          w_rem_nxt = r_rem - 2'd1;
          if (r_rem <= 2'd1) begin
            w_state_nxt = c_RUN;
            w_rem_nxt   = 2'd0;
          end
        end
        default: begin
          w_state_nxt = c_RUN;
          w_rem_nxt   = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_idex_bubble = 1'b0;
    w_ifid_flush  = 1'b0;
    w_exmem_hold  = 1'b0;
    if (!reset_n) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
      w_ifid_flush  = 1'b1;
    end else if (w_freeze) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_exmem_hold = 1'b1;
    end else begin
      case (r_state)
        c_LOAD_STALL: begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
        end
        c_FLUSH: w_ifid_flush = 1'b1;
        default: begin
          // A branch alongside a load-use hazard read a stale operand
          if (w_hazard) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
          end else if (hz.branch_taken) begin
            w_ifid_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait         <= '0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= 16'd0;
    end else begin
      if (w_freeze) begin
        r_wait <= r_wait + 1'b1;
        if (r_wait == c_WAIT_MAX - 1'b1) r_mem_timeout <= 1'b1;
      end else begin
        r_wait <= '0;
      end
      if (!w_pc_write && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign hz.pc_write     = w_pc_write;
  assign hz.ifid_write   = w_ifid_write;
  assign hz.idex_bubble  = w_idex_bubble;
  assign hz.ifid_flush   = w_ifid_flush;
  assign hz.exmem_hold   = w_exmem_hold;
  assign hz.mem_timeout  = r_mem_timeout;
  assign hz.stall_cycles = r_stall_cycles;
endmodule
`default_nettype wire
